uart_hex_fmt_tx: RTL and testbench

Parametrised word-to-ASCII-hex formatter feeding a UART byte transmitter.
- Buffers DATA_W-bit words in an internal word FIFO.
- Renders each word as uppercase hex with optional "0x" prefix, optional leading-zero suppression and a selectable terminator.
- Emits bytes over a valid/ready byte stream to the UART TX core.
- Successor to the fixed-width CR/LF hex dumper: generalised width, buffering and output modes.

---
 rtl/uart_hex_fmt_tx.sv | 164 ++++++++++++++++
 tb/tb_uart_hex_fmt_tx.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_fmt_tx.sv
// Word FIFO feeding an ASCII hex formatter that drives a valid/ready byte stream to a UART TX core.
// Each word prints as uppercase hex, with optional "0x" prefix, leading-zero suppression and terminator.
//
// state | meaning
// IDLE  | no word in flight, o_byte_vld low
// PFX0  | presenting "0"
// PFX1  | presenting "x"
// NIB   | presenting hex digit k (msb first)
// TERM1 | presenting space, LF or CR
// TERM2 | presenting LF after CR
module uart_hex_fmt_tx #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_stb,
  output logic              o_tx_rdy,
  input  logic              i_prefix,
  input  logic              i_nolz,
  input  logic [1:0]        i_term,
  output logic [7:0]        o_byte,
  output logic              o_byte_vld,
  input  logic              i_byte_rdy,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_fifo_cnt
);

  localparam int NDIG = DATA_W / 4;
  localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int PW   = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, PFX0, PFX1, NIB, TERM1, TERM2} state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  state_t            state;
  logic [DATA_W-1:0] word;
  logic [KW-1:0]     k, k_m1, start_k;
  logic [1:0]        term_q;
  logic              wr_en, rd_en, hs, last_byte;
  logic [DATA_W-1:0] head;
  logic [CNT_W-1:0]  cnt_next;
  logic [3:0]        nib_head, nib_cur, nib_nxt;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] term_char(input logic [1:0] t);
    case (t)
      2'd1:    return 8'h20;
      2'd2:    return 8'h0A;
      2'd3:    return 8'h0D;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    head      = mem[rd_ptr];
    wr_en     = i_tx_stb & o_tx_rdy;
    hs        = o_byte_vld & i_byte_rdy;
    last_byte = ((state == NIB) && (k == '0) && (term_q == 2'd0)) ||
                ((state == TERM1) && (term_q != 2'd3)) ||
                (state == TERM2);
    // popping on the last handshake lets the next word follow with no bubble
    rd_en     = (o_fifo_cnt != '0) && ((state == IDLE) || (hs && last_byte));
    cnt_next  = o_fifo_cnt + CNT_W'(wr_en) - CNT_W'(rd_en);
    start_k   = KW'(NDIG - 1);
    if (i_nolz) begin
      start_k = '0;
      for (int i = 1; i < NDIG; i++)
        if (head[4*i +: 4] != 4'h0) start_k = KW'(i);
    end
    k_m1     = k - 1'b1;
    nib_head = head[4*int'(start_k) +: 4];
    nib_cur  = word[4*int'(k) +: 4];
    nib_nxt  = word[4*int'(k_m1) +: 4];
  end

  assign o_busy = (o_fifo_cnt != '0) | (state != IDLE) | o_byte_vld;

  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= i_tx_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_fifo_cnt <= '0;
      o_tx_rdy   <= 1'b1;
      state      <= IDLE;
      word       <= '0;
      k          <= '0;
      term_q     <= 2'd0;
      o_byte     <= 8'h00;
      o_byte_vld <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      o_fifo_cnt <= cnt_next;
      o_tx_rdy   <= (cnt_next != CNT_W'(DEPTH));
      if (rd_en) begin
        word       <= head;
        k          <= start_k;
        term_q     <= i_term;
        o_byte_vld <= 1'b1;
        if (i_prefix) begin
          state  <= PFX0;
          o_byte <= 8'h30;
        end else begin
          state  <= NIB;
          o_byte <= hex_char(nib_head);
        end
      end else if (hs) begin
        case (state)
          PFX0: begin
            state  <= PFX1;
            o_byte <= 8'h78;
          end
          PFX1: begin
            state  <= NIB;
            o_byte <= hex_char(nib_cur);
          end
          NIB: begin
            if (k != '0) begin
              k      <= k_m1;
              o_byte <= hex_char(nib_nxt);
            end else if (term_q != 2'd0) begin
              state  <= TERM1;
              o_byte <= term_char(term_q);
            end else begin
              state      <= IDLE;
              o_byte     <= 8'h00;
              o_byte_vld <= 1'b0;
            end
          end
          TERM1: begin
            if (term_q == 2'd3) begin
              state  <= TERM2;
              o_byte <= 8'h0A;
            end else begin
              state      <= IDLE;
              o_byte     <= 8'h00;
              o_byte_vld <= 1'b0;
            end
          end
          TERM2: begin
            state      <= IDLE;
            o_byte     <= 8'h00;
            o_byte_vld <= 1'b0;
          end
          default: begin
            state      <= IDLE;
            o_byte_vld <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_hex_fmt_tx.sv
// Bench for uart_hex_fmt_tx: directed scenarios plus randomized words checked against a
// string-level hex formatting model.
module tb_uart_hex_fmt_tx;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] i_tx_data = '0;
  logic              i_tx_stb = 1'b0;
  logic              o_tx_rdy;
  logic              i_prefix = 1'b0;
  logic              i_nolz = 1'b0;
  logic [1:0]        i_term = 2'd0;
  logic [7:0]        o_byte;
  logic              o_byte_vld;
  logic              i_byte_rdy = 1'b0;
  logic              o_busy;
  logic [CNT_W-1:0]  o_fifo_cnt;

  uart_hex_fmt_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .i_tx_data(i_tx_data), .i_tx_stb(i_tx_stb), .o_tx_rdy(o_tx_rdy),
    .i_prefix(i_prefix), .i_nolz(i_nolz), .i_term(i_term), .o_byte(o_byte),
    .o_byte_vld(o_byte_vld), .i_byte_rdy(i_byte_rdy), .o_busy(o_busy), .o_fifo_cnt(o_fifo_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q [$];
  logic [7:0] rx_q [$];
  int         rx_cyc [$];
  int         errors = 0;
  int         checks = 0;

  // handshake seen at negedge completes on the following posedge
  always @(negedge clk)
    if (!rst && o_byte_vld && i_byte_rdy) begin
      rx_q.push_back(o_byte);
      rx_cyc.push_back(cyc);
    end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w);
    i_tx_data = w;
    i_tx_stb  = 1'b1;
    tick();
    i_tx_stb  = 1'b0;
  endtask

  task automatic clear_q();
    exp_q.delete();
    rx_q.delete();
    rx_cyc.delete();
  endtask

  function automatic void model_word(input logic [15:0] w, input logic pfx, input logic nolz,
                                     input logic [1:0] term);
    int start;
    int d;
    start = 3;
    if (nolz) begin
      start = 0;
      for (int i = 0; i < 4; i++)
        if (((w >> (4 * i)) & 16'hF) != 16'h0) start = i;
    end
    if (pfx) begin
      exp_q.push_back(8'h30);
      exp_q.push_back(8'h78);
    end
    for (int i = start; i >= 0; i--) begin
      d = int'((w >> (4 * i)) & 16'hF);
      exp_q.push_back((d < 10) ? 8'(48 + d) : 8'(55 + d));
    end
    case (term)
      2'd1: exp_q.push_back(8'h20);
      2'd2: exp_q.push_back(8'h0A);
      2'd3: begin
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
      end
      default: ;
    endcase
  endfunction

  task automatic drain(input bit rnd, input string name);
    int budget;
    budget = 3000;
    while ((rx_q.size() < exp_q.size() || o_busy) && budget > 0) begin
      i_byte_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      budget--;
    end
    i_byte_rdy = 1'b1;
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d bytes busy=%0b, required %0d bytes and idle",
               name, rx_q.size(), o_busy, exp_q.size());
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d bytes, required %0d", name, rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_byte%0d: got %02h, required %02h", name, i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic check_back_to_back(input string name);
    for (int i = 1; i < rx_cyc.size(); i++) begin
      checks++;
      if (rx_cyc[i] !== rx_cyc[0] + i) begin
        errors++;
        $display("FAIL %s_gap%0d: got handshake cycle %0d, required %0d",
                 name, i, rx_cyc[i], rx_cyc[0] + i);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (o_byte_vld !== 1'b0) begin errors++; $display("FAIL rst_vld: got %0b, required 0", o_byte_vld); end
    checks++; if (o_byte !== 8'h00) begin errors++; $display("FAIL rst_byte: got %02h, required 00", o_byte); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b, required 0", o_busy); end
    checks++; if (o_fifo_cnt !== '0) begin errors++; $display("FAIL rst_cnt: got %0d, required 0", o_fifo_cnt); end
    checks++; if (o_tx_rdy !== 1'b1) begin errors++; $display("FAIL rst_txrdy: got %0b, required 1", o_tx_rdy); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++; if (o_tx_rdy !== 1'b1 || o_busy !== 1'b0) begin
      errors++; $display("FAIL post_rst_idle: got txrdy=%0b busy=%0b, required 1 0", o_tx_rdy, o_busy);
    end
  endtask

  task automatic test_basic();
    clear_q();
    i_byte_rdy = 1'b1; i_prefix = 1'b0; i_nolz = 1'b0; i_term = 2'd3;
    model_word(16'h1A2F, 1'b0, 1'b0, 2'd3);
    push_word(16'h1A2F);
    checks++; if (o_fifo_cnt !== 3'd1 || o_byte_vld !== 1'b0) begin
      errors++; $display("FAIL basic_write: got cnt=%0d vld=%0b, required 1 0", o_fifo_cnt, o_byte_vld);
    end
    tick();
    checks++; if (o_byte_vld !== 1'b1 || o_byte !== 8'h31 || o_fifo_cnt !== 3'd0) begin
      errors++; $display("FAIL basic_latency: got vld=%0b byte=%02h cnt=%0d, required 1 31 0",
                         o_byte_vld, o_byte, o_fifo_cnt);
    end
    drain(1'b0, "basic");
    check_back_to_back("basic");
    if (rx_cyc.size() > 0) begin
      checks++;
      if (cyc !== rx_cyc[rx_cyc.size()-1] + 1) begin
        errors++; $display("FAIL basic_busy_fall: got idle at cycle %0d, required %0d",
                           cyc, rx_cyc[rx_cyc.size()-1] + 1);
      end
    end
  endtask

  task automatic test_nolz();
    clear_q();
    i_byte_rdy = 1'b1; i_prefix = 1'b0; i_nolz = 1'b1; i_term = 2'd1;
    model_word(16'h0000, 1'b0, 1'b1, 2'd1);
    push_word(16'h0000);
    tick();
    i_prefix = 1'b1;
    model_word(16'h00B0, 1'b1, 1'b1, 2'd1);
    push_word(16'h00B0);
    drain(1'b0, "nolz");
    check_back_to_back("nolz");
    i_prefix = 1'b0; i_nolz = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [15:0] w;
    logic [7:0]  hold_b;
    int          budget;
    clear_q();
    w = 16'($urandom);
    i_byte_rdy = 1'b1; i_prefix = 1'($urandom); i_nolz = 1'b0; i_term = 2'($urandom);
    model_word(w, i_prefix, 1'b0, i_term);
    push_word(w);
    budget = 50;
    while (rx_q.size() < 2 && budget > 0) begin
      tick();
      budget--;
    end
    i_byte_rdy = 1'b0;
    hold_b = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) hold_b = o_byte;
      checks++;
      if (o_byte_vld !== 1'b1 || o_byte !== hold_b || o_byte !== exp_q[2]) begin
        errors++; $display("FAIL bp_hold%0d: got vld=%0b byte=%02h, required 1 %02h",
                           i, o_byte_vld, o_byte, exp_q[2]);
      end
    end
    tick();
    drain(1'b0, "backpressure");
  endtask

  task automatic test_fill();
    logic [15:0] w;
    clear_q();
    i_byte_rdy = 1'b0; i_prefix = 1'($urandom); i_nolz = 1'($urandom); i_term = 2'($urandom);
    for (int i = 0; i < DEPTH + 3; i++) begin
      w = 16'($urandom);
      if (i <= DEPTH) model_word(w, i_prefix, i_nolz, i_term);
      push_word(w);
    end
    checks++; if (o_tx_rdy !== 1'b0) begin errors++; $display("FAIL fill_txrdy: got %0b, required 0", o_tx_rdy); end
    checks++; if (o_fifo_cnt !== 3'(DEPTH)) begin errors++; $display("FAIL fill_cnt: got %0d, required %0d", o_fifo_cnt, DEPTH); end
    checks++; if (o_byte_vld !== 1'b1) begin errors++; $display("FAIL fill_vld: got %0b, required 1", o_byte_vld); end
    drain(1'b1, "fill");
  endtask

  task automatic test_mode_change();
    logic [15:0] wa, wb;
    clear_q();
    wa = 16'($urandom); wb = 16'($urandom);
    i_byte_rdy = 1'b1; i_prefix = 1'b0; i_nolz = 1'b0; i_term = 2'd3;
    model_word(wa, 1'b0, 1'b0, 2'd3);
    push_word(wa);
    tick();
    i_term = 2'd0;
    model_word(wb, 1'b0, 1'b0, 2'd0);
    push_word(wb);
    drain(1'b0, "mode_change");
  endtask

  task automatic test_random();
    logic [15:0] w;
    int          n;
    for (int b = 0; b < 4; b++) begin
      clear_q();
      i_prefix = 1'($urandom); i_nolz = 1'($urandom); i_term = 2'($urandom);
      n = $urandom_range(1, DEPTH + 1);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 3))
          0:       w = 16'h0000;
          1:       w = 16'($urandom_range(0, 255));
          default: w = 16'($urandom);
        endcase
        model_word(w, i_prefix, i_nolz, i_term);
        i_byte_rdy = 1'($urandom_range(0, 1));
        push_word(w);
      end
      drain(1'b1, "random");
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] w;
    clear_q();
    i_byte_rdy = 1'b0; i_prefix = 1'b0; i_nolz = 1'b0; i_term = 2'd2;
    push_word(16'($urandom));
    push_word(16'($urandom));
    tick();
    checks++; if (o_byte_vld !== 1'b1) begin errors++; $display("FAIL arst_pre_vld: got %0b, required 1", o_byte_vld); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (o_byte_vld !== 1'b0 || o_byte !== 8'h00) begin
      errors++; $display("FAIL arst_out: got vld=%0b byte=%02h, required 0 00", o_byte_vld, o_byte);
    end
    checks++; if (o_fifo_cnt !== '0 || o_busy !== 1'b0 || o_tx_rdy !== 1'b1) begin
      errors++; $display("FAIL arst_fifo: got cnt=%0d busy=%0b txrdy=%0b, required 0 0 1",
                         o_fifo_cnt, o_busy, o_tx_rdy);
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    clear_q();
    tick();
    i_byte_rdy = 1'b1; i_term = 2'($urandom);
    w = 16'($urandom);
    model_word(w, 1'b0, 1'b0, i_term);
    push_word(w);
    drain(1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nolz();
    test_backpressure();
    test_fill();
    test_mode_change();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
